// File: rtl/meta_egress_queue.sv
// Egress queue behind the metadata-modification ALU: captures the composite word,
// drops discard-flagged packets, buffers survivors in a FWFT FIFO, keeps drop/overflow stats.
module meta_egress_queue #(
  parameter int META_LEN = 256,
  parameter int COMP_LEN = 100,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [META_LEN+COMP_LEN-1:0]     comp_meta_data_in,
  input  logic                             comp_meta_data_valid_in,
  output logic                             stage_ready_out,
  output logic [META_LEN+COMP_LEN-1:0]     comp_meta_data_out,
  output logic [7:0]                       dst_port_out,
  output logic [5:0]                       next_table_id_out,
  output logic                             meta_valid_out,
  input  logic                             meta_ready_in,
  input  logic                             clr_cnt,
  output logic [CNT_W-1:0]                 drop_cnt,
  output logic [CNT_W-1:0]                 ovf_cnt,
  output logic [$clog2(DEPTH):0]           fifo_level
);

  localparam int W  = META_LEN + COMP_LEN;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - 2);

  logic [W-1:0]     cap_word_q;
  logic             cap_valid_q;
  logic             cap_discard_q;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             stage_ready_q, stage_ready_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic full, pop, push, drop_inc, ovf_inc;

  always_comb begin
    full     = (level_q == FULL_LVL);
    pop      = (level_q != '0) && meta_ready_in;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    push     = cap_valid_q && !cap_discard_q && (!full || pop);
    drop_inc = cap_valid_q && cap_discard_q;
    ovf_inc  = cap_valid_q && !cap_discard_q && full && !pop;

    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d       = level_q + LW'(push) - LW'(pop);
    stage_ready_d = (level_d <= AF_LVL);

    drop_cnt_d = drop_cnt_q;
    if (clr_cnt)
      drop_cnt_d = '0;
    else if (drop_inc && !(&drop_cnt_q))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);

    ovf_cnt_d = ovf_cnt_q;
    if (clr_cnt)
      ovf_cnt_d = '0;
    else if (ovf_inc && !(&ovf_cnt_q))
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_word_q    <= '0;
      cap_valid_q   <= 1'b0;
      cap_discard_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      stage_ready_q <= 1'b0;
      drop_cnt_q    <= '0;
      ovf_cnt_q     <= '0;
    end else begin
      cap_word_q    <= comp_meta_data_in;
      cap_valid_q   <= comp_meta_data_valid_in;
      cap_discard_q <= comp_meta_data_in[128];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      stage_ready_q <= stage_ready_d;
      drop_cnt_q    <= drop_cnt_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the level.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= cap_word_q;
  end

  always_comb begin
    meta_valid_out     = (level_q != '0);
    comp_meta_data_out = meta_valid_out ? mem_q[rd_ptr_q] : '0;
    dst_port_out       = comp_meta_data_out[31:24];
    next_table_id_out  = comp_meta_data_out[W-1 -: 6];
    stage_ready_out    = stage_ready_q;
    drop_cnt           = drop_cnt_q;
    ovf_cnt            = ovf_cnt_q;
    fifo_level         = level_q;
  end

endmodule

// File: tb/tb_meta_egress_queue.sv
// Directed bench for meta_egress_queue: latency, discard, overflow, full push+pop,
// counter saturation/clear and asynchronous reset flush.
module tb_meta_egress_queue;

  localparam int META_LEN = 256;
  localparam int COMP_LEN = 100;
  localparam int W        = META_LEN + COMP_LEN;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     din = '0;
  logic             din_valid = 1'b0;
  logic             stage_ready;
  logic [W-1:0]     dout;
  logic [7:0]       dst_port;
  logic [5:0]       next_table_id;
  logic             meta_valid;
  logic             meta_ready = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] ovf_cnt;
  logic [2:0]       fifo_level;

  int errors = 0;
  int checks = 0;

  meta_egress_queue #(
    .META_LEN(META_LEN), .COMP_LEN(COMP_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .comp_meta_data_in(din), .comp_meta_data_valid_in(din_valid),
    .stage_ready_out(stage_ready),
    .comp_meta_data_out(dout), .dst_port_out(dst_port), .next_table_id_out(next_table_id),
    .meta_valid_out(meta_valid), .meta_ready_in(meta_ready),
    .clr_cnt(clr_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] dst, input logic [5:0] ntid,
                                      input logic disc, input logic [31:0] tag);
    logic [W-1:0] w;
    w = '0;
    w[31:24]   = dst;
    w[W-1 -: 6] = ntid;
    w[128]     = disc;
    w[95:64]   = tag;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle; returns just after the capturing edge.
  task automatic drive(input logic [W-1:0] w);
    $display("send dst=%02h ntid=%02h discard=%0b tag=%0h", w[31:24], w[W-1 -: 6], w[128], w[95:64]);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  logic [W-1:0] wq [6];

  initial begin
    // Reset state
    #12;
    check("rst_valid", meta_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_stage_ready", stage_ready, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_dout", dout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_stage_ready", stage_ready, 1);

    // 1: single word, 2-cycle latency, one-cycle valid with ready held high
    meta_ready = 1'b1;
    wq[0] = mk(8'h05, 6'h03, 1'b0, 32'h1);
    drive(wq[0]);
    check("t1_valid_e1", meta_valid, 0);
    tick();
    check("t1_valid_e2", meta_valid, 1);
    check("t1_dst", dst_port, 8'h05);
    check("t1_ntid", next_table_id, 6'h03);
    check("t1_word", dout, wq[0]);
    tick();
    check("t1_valid_e3", meta_valid, 0);
    check("t1_drop", drop_cnt, 0);

    // 2: discard, keep, discard back to back
    wq[0] = mk(8'h11, 6'h01, 1'b1, 32'h21);
    wq[1] = mk(8'h12, 6'h02, 1'b0, 32'h22);
    wq[2] = mk(8'h13, 6'h03, 1'b1, 32'h23);
    drive(wq[0]);
    check("t2_valid_a", meta_valid, 0);
    din = wq[1]; din_valid = 1'b1; tick();
    check("t2_valid_b", meta_valid, 0);
    din = wq[2]; tick();
    din_valid = 1'b0;
    check("t2_valid_c", meta_valid, 1);
    check("t2_word", dout, wq[1]);
    tick();
    check("t2_valid_d", meta_valid, 0);
    check("t2_drop", drop_cnt, 2);
    check("t2_level", fifo_level, 0);

    // 3: six words against a stalled output
    clear_counters();
    meta_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wq[i] = mk(8'h30 + 8'(i), 6'(i), 1'b0, 32'h300 + i);
      drive(wq[i]);
      check($sformatf("t3_level_%0d", i), fifo_level, (i > 4) ? 4 : i);
      check($sformatf("t3_sready_%0d", i), stage_ready, (i <= 2) ? 1 : 0);
    end
    tick();
    check("t3_level_full", fifo_level, 4);
    check("t3_ovf", ovf_cnt, 2);
    check("t3_hold_word", dout, wq[0]);
    meta_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_drain_%0d", k), dout, wq[k]);
      tick();
    end
    check("t3_empty_valid", meta_valid, 0);
    check("t3_empty_level", fifo_level, 0);

    // 4: push and pop together while full
    clear_counters();
    meta_ready = 1'b0;
    for (int i = 0; i < 5; i++) wq[i] = mk(8'h40 + 8'(i), 6'h10 + 6'(i), 1'b0, 32'h400 + i);
    for (int i = 0; i < 4; i++) drive(wq[i]);
    tick();
    check("t4_full", fifo_level, 4);
    drive(wq[4]);
    meta_ready = 1'b1;
    tick();
    meta_ready = 1'b0;
    check("t4_level", fifo_level, 4);
    check("t4_ovf", ovf_cnt, 0);
    check("t4_head", dout, wq[1]);
    meta_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("t4_drain_%0d", k), dout, wq[k]);
      tick();
    end
    check("t4_empty", fifo_level, 0);

    // 5: drop counter saturation and clear priority
    clear_counters();
    din = mk(8'h55, 6'h05, 1'b1, 32'h500);
    din_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    din_valid = 1'b0;
    tick();
    check("t5_drop15", drop_cnt, 15);
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    din_valid = 1'b0;
    tick();
    check("t5_drop_sat", drop_cnt, 15);
    drive(mk(8'h56, 6'h06, 1'b1, 32'h501));
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t5_clr_prio", drop_cnt, 0);
    drive(mk(8'h57, 6'h07, 1'b1, 32'h502));
    tick();
    check("t5_after_clr", drop_cnt, 1);

    // 6: asynchronous reset flush with words buffered
    meta_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(mk(8'h60 + 8'(i), 6'h20, 1'b0, 32'h600 + i));
    tick();
    check("t6_pre_level", fifo_level, 3);
    check("t6_pre_valid", meta_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", meta_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_ovf", ovf_cnt, 0);
    tick();
    rst_n = 1'b1;
    meta_ready = 1'b1;
    tick();
    check("t6_sready", stage_ready, 1);
    wq[0] = mk(8'h66, 6'h26, 1'b0, 32'h666);
    drive(wq[0]);
    check("t6_lat_e1", meta_valid, 0);
    tick();
    check("t6_lat_e2", meta_valid, 1);
    check("t6_word", dout, wq[0]);
    tick();
    check("t6_lat_e3", meta_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/meta_egress_queue.md
Name: meta_egress_queue

Overview:
- Sits directly downstream of the metadata-modification ALU (type 3) at the end of each RMT stage.
- Takes the composite word {metadata, comp_ins} with its valid strobe and decodes the fields that ALU wrote.
- Drops packets flagged for discard and buffers the survivors in a small FIFO.
- Presents them to the next stage or deparser over a valid/ready handshake. Also keeps drop and overflow statistics.

Parameters:
- META_LEN, 256: metadata width.
- COMP_LEN, 100: comp_ins width. The composite word is W = META_LEN+COMP_LEN = 356 bits.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥ 2.
- CNT_W, 32: statistics counter width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- comp_meta_data_in, input, W: composite word from the ALU.
- comp_meta_data_valid_in, input, 1: word valid. Single-cycle strobe; there is no ready back to the ALU.
- stage_ready_out, output, 1: almost-full advisory to upstream stage control.
- comp_meta_data_out, output, W: buffered composite word.
- dst_port_out, output, 8: comp_meta_data_out[31:24].
- next_table_id_out, output, 6: comp_meta_data_out[355:350].
- meta_valid_out, output, 1: output word valid.
- meta_ready_in, input, 1: downstream accepts.
- clr_cnt, input, 1: synchronous clear of both counters.
- drop_cnt, output, CNT_W: words discarded by the discard flag.
- ovf_cnt, output, CNT_W: words lost because the FIFO was full.
- fifo_level, output, $clog2(DEPTH)+1: current occupancy.

Behaviour:

Reset:
- All outputs and internal state go to 0, including FIFO pointers and level, counters, and the capture register.
- Consequently stage_ready_out is 0 during reset and returns to 1 on the first clk after rst_n deasserts.
- Reset asserted mid-operation flushes all buffered words without incrementing any counter.

Stage 1, capture (1 cycle):
- On every clk, cap_word <= comp_meta_data_in and cap_valid <= comp_meta_data_valid_in.
- cap_discard = comp_meta_data_in[128], registered at the same time.

Stage 2, classify and push (same cycle as cap_valid):
- cap_valid & cap_discard: word not written; drop_cnt increments.
- cap_valid & ~cap_discard & (~full | pop): word written at the write pointer.
- cap_valid & ~cap_discard & full & ~pop: word lost; ovf_cnt increments.

FIFO and handshake:
- pop = meta_valid_out & meta_ready_in.
- Output is first-word-fall-through: meta_valid_out = (level != 0), and comp_meta_data_out = entry at the read pointer.
- Output fields are stable while meta_valid_out & ~meta_ready_in.
- Simultaneous push and pop: level unchanged. When full, the freed slot accepts the push.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- Latency: input valid at edge N is visible at meta_valid_out after edge N+2 when the FIFO is empty.
- stage_ready_out = (level <= DEPTH-2), registered from next-state level.

Counters:
- Saturate at all-ones; no wrap.
- clr_cnt takes priority over a same-cycle increment; the result is 0.

Ordering:
- Output order equals arrival order of non-discarded words.

Test Plan:
1. Single word, discard bit 0, dst_port 8'h05, next_table_id 6'h03, meta_ready_in held 1 → meta_valid_out high for exactly 1 cycle, 2 cycles after input; dst_port_out=05, next_table_id_out=03; drop_cnt=0.
2. Three back-to-back words with bit[128]=1, 0, 1 → only the middle word appears on the output; drop_cnt=2; fifo_level returns to 0.
3. meta_ready_in=0 while 6 valid non-discard words stream in (DEPTH=4) → level sticks at 4; ovf_cnt=2; stage_ready_out falls when level reaches 3. Then raising ready drains words 1-4 in order.
4. FIFO full, with a push and meta_ready_in=1 in the same cycle → no overflow; level stays 4; ovf_cnt unchanged; the next word out is the former second entry.
5. drop_cnt preloaded to all-ones via repeated drops (CNT_W=4: 15 drops, then 3 more) → stays 15. clr_cnt coincident with a drop → 0.
6. rst_n pulsed low with 3 words buffered and meta_valid_out high → meta_valid_out=0 and fifo_level=0 immediately (async); counters 0; a new word after release emerges with the standard 2-cycle latency.
